ga_crossover_thresh_gen: RTL and testbench



---
 rtl/ga_pkg.sv | 15 +
 rtl/ga_xover_thresh_match.sv | 55 +++++
 rtl/ga_crossover_thresh_gen.sv | 137 +++++++++++++
 tb/tb_ga_crossover_thresh_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga_pkg.sv
// Shared GA definitions: crossover-threshold FSM states and fixed-point helpers.
package ga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    READY = 2'd2
  } ga_xover_thresh_state_t;

  // Unsigned fixed-point 1.0 for a given number of fraction bits.
  function automatic logic [31:0] fix_one(input int unsigned fract_w);
    return 32'd1 << fract_w;
  endfunction

endpackage

// File: rtl/ga_xover_thresh_match.sv
// Two-stage query pipeline: registered compare vector against the threshold
// table, then a registered popcount giving the crossover cut index.
module ga_xover_thresh_match #(
  parameter int DATA_W      = 8,
  parameter int FIT_SCORE_W = 16,
  parameter int CUT_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FIT_SCORE_W-1:0] thresh_ary [0:DATA_W-1],
  input  logic                   query_vld,
  input  logic                   query_rdy,
  input  logic [FIT_SCORE_W-1:0] query_score,
  output logic                   resp_vld,
  output logic [CUT_W-1:0]       resp_cut
);

  logic [DATA_W-1:0] cmp_q, cmp_d;
  logic              s1_vld_q, s1_vld_d;
  logic              resp_vld_q, resp_vld_d;
  logic [CUT_W-1:0]  resp_cut_q, resp_cut_d;

  always_comb begin
    s1_vld_d   = query_vld && query_rdy;
    cmp_d      = cmp_q;
    resp_vld_d = s1_vld_q;
    resp_cut_d = resp_cut_q;
    if (s1_vld_d) begin
      for (int i = 0; i < DATA_W; i++) cmp_d[i] = (thresh_ary[i] <= query_score);
    end
    // Thresholds are not guaranteed monotonic, so count every hit.
    if (s1_vld_q) begin
      resp_cut_d = '0;
      for (int i = 0; i < DATA_W; i++) resp_cut_d = resp_cut_d + CUT_W'(cmp_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q      <= '0;
      s1_vld_q   <= 1'b0;
      resp_vld_q <= 1'b0;
      resp_cut_q <= '0;
    end else begin
      cmp_q      <= cmp_d;
      s1_vld_q   <= s1_vld_d;
      resp_vld_q <= resp_vld_d;
      resp_cut_q <= resp_cut_d;
    end
  end

  assign resp_vld = resp_vld_q;
  assign resp_cut = resp_cut_q;

endmodule

// File: rtl/ga_crossover_thresh_gen.sv
// Crossover threshold table builder (one entry per cycle) plus query matcher.
// Define GA_XOVER_THRESH_LINEAR_EN to enable linear spacing via cnfg_lin_mode.
module ga_crossover_thresh_gen
  import ga_pkg::*;
#(
  parameter  int DATA_W            = 8,
  parameter  int FIT_SCORE_W       = 16,
  parameter  int FIT_SCORE_INT_W   = 8,
  parameter  int FIT_SCORE_FRACT_W = 8,
  localparam int CUT_W             = $clog2(DATA_W + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cnfg_update,
  input  logic [FIT_SCORE_W-1:0] cnfg_max_fit_score,
  input  logic                   cnfg_lin_mode,
  output logic [FIT_SCORE_W-1:0] thresh_ary [0:DATA_W-1],
  output logic                   thresh_vld,
  input  logic                   query_vld,
  input  logic [FIT_SCORE_W-1:0] query_score,
  output logic                   query_rdy,
  output logic                   resp_vld,
  output logic [CUT_W-1:0]       resp_cut
);

  if (DATA_W < 2 || (DATA_W & (DATA_W - 1)) != 0) begin : g_bad_data_w
    $error("DATA_W must be a power of two >= 2");
  end
  if (FIT_SCORE_INT_W + FIT_SCORE_FRACT_W != FIT_SCORE_W) begin : g_bad_fit_w
    $error("FIT_SCORE_INT_W + FIT_SCORE_FRACT_W must equal FIT_SCORE_W");
  end

  localparam int                     IDX_W     = $clog2(DATA_W);
  localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(DATA_W - 1);
  localparam logic [FIT_SCORE_W-1:0] ONE_FX    = FIT_SCORE_W'(fix_one(FIT_SCORE_FRACT_W));
  localparam logic [FIT_SCORE_W-1:0] EXP_FIRST = ONE_FX >> (DATA_W - 1);

  ga_xover_thresh_state_t state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FIT_SCORE_W-1:0] max_q, max_d;
  logic [FIT_SCORE_W-1:0] thresh_q [0:DATA_W-1];
  logic [FIT_SCORE_W-1:0] thresh_d [0:DATA_W-1];
  logic [FIT_SCORE_W-1:0] entry;

`ifdef GA_XOVER_THRESH_LINEAR_EN
  logic                   mode_q, mode_d;
  logic [FIT_SCORE_W-1:0] acc_q, acc_d;
  logic [FIT_SCORE_W-1:0] step;

  assign step = max_q >> $clog2(DATA_W);
`else
  logic lin_mode_unused;
  assign lin_mode_unused = cnfg_lin_mode;
`endif

  always_comb begin
    entry = (idx_q == '0) ? EXP_FIRST : (max_q >> (DATA_W - int'(idx_q)));
`ifdef GA_XOVER_THRESH_LINEAR_EN
    if (mode_q) entry = acc_q + step;
`endif
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path leaves a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    max_d    = max_q;
    thresh_d = thresh_q;
`ifdef GA_XOVER_THRESH_LINEAR_EN
    mode_d   = mode_q;
    acc_d    = acc_q;
`endif
    if (cnfg_update) begin
      state_d = CALC;
      idx_d   = '0;
      max_d   = cnfg_max_fit_score;
`ifdef GA_XOVER_THRESH_LINEAR_EN
      mode_d  = cnfg_lin_mode;
      acc_d   = '0;
`endif
    end else if (state_q == CALC) begin
      thresh_d[idx_q] = entry;
`ifdef GA_XOVER_THRESH_LINEAR_EN
      acc_d = acc_q + step;
`endif
      if (idx_q == IDX_LAST) begin
        state_d = READY;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      max_q    <= '0;
      // NOTE: the table is a handful of flops with a defined reset value, not a RAM.
      thresh_q <= '{default: '0};
`ifdef GA_XOVER_THRESH_LINEAR_EN
      mode_q   <= 1'b0;
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      max_q    <= max_d;
      thresh_q <= thresh_d;
`ifdef GA_XOVER_THRESH_LINEAR_EN
      mode_q   <= mode_d;
      acc_q    <= acc_d;
`endif
    end
  end

  assign thresh_ary = thresh_q;
  assign thresh_vld = (state_q == READY);
  assign query_rdy  = (state_q == READY) && !cnfg_update;

  ga_xover_thresh_match #(
    .DATA_W      (DATA_W),
    .FIT_SCORE_W (FIT_SCORE_W),
    .CUT_W       (CUT_W)
  ) u_match (
    .clk         (clk),
    .rst         (rst),
    .thresh_ary  (thresh_q),
    .query_vld   (query_vld),
    .query_rdy   (query_rdy),
    .query_score (query_score),
    .resp_vld    (resp_vld),
    .resp_cut    (resp_cut)
  );

endmodule

// File: tb/tb_ga_crossover_thresh_gen.sv
// Randomized self-checking bench for ga_crossover_thresh_gen against an
// arithmetic reference model of the threshold table and cut index.
module tb_ga_crossover_thresh_gen;

  logic        clk;
  logic        rst;
  logic        cnfg_update;
  logic [15:0] cnfg_max_fit_score;
  logic        cnfg_lin_mode;
  logic [15:0] thresh_ary [0:7];
  logic        thresh_vld;
  logic        query_vld;
  logic [15:0] query_score;
  logic        query_rdy;
  logic        resp_vld;
  logic [3:0]  resp_cut;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int cut;
    int cyc;
  } exp_t;

  exp_t        sb [$];
  exp_t        got_e;
  logic [15:0] m_tbl [8];

  ga_crossover_thresh_gen #(
    .DATA_W            (8),
    .FIT_SCORE_W       (16),
    .FIT_SCORE_INT_W   (8),
    .FIT_SCORE_FRACT_W (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cnfg_update        (cnfg_update),
    .cnfg_max_fit_score (cnfg_max_fit_score),
    .cnfg_lin_mode      (cnfg_lin_mode),
    .thresh_ary         (thresh_ary),
    .thresh_vld         (thresh_vld),
    .query_vld          (query_vld),
    .query_score        (query_score),
    .query_rdy          (query_rdy),
    .resp_vld           (resp_vld),
    .resp_cut           (resp_cut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Thresholds straight from the arithmetic definition: 1.0 = 256, 8 bits.
  function automatic void model_build(input int mx, input bit lin);
    bit use_lin;
    use_lin = 1'b0;
`ifdef GA_XOVER_THRESH_LINEAR_EN
    use_lin = lin;
`endif
    for (int i = 0; i < 8; i++) begin
      if (use_lin)     m_tbl[i] = 16'((i + 1) * (mx / 8));
      else if (i == 0) m_tbl[i] = 16'(256 / 128);
      else             m_tbl[i] = 16'(mx / (1 << (8 - i)));
    end
  endfunction

  function automatic int model_cut(input logic [15:0] score);
    int n = 0;
    foreach (m_tbl[i]) if (m_tbl[i] <= score) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    if (!rst && resp_vld) begin
      if (sb.size() == 0) begin
        check("spurious_resp", 32'd1, 32'd0);
      end else begin
        got_e = sb.pop_front();
        check("resp_cut", 32'(resp_cut), 32'(got_e.cut));
        check("resp_latency", 32'(cyc), 32'(got_e.cyc + 1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [15:0] mx, input logic lin);
    query_vld          = 1'b0;
    cnfg_max_fit_score = mx;
    cnfg_lin_mode      = lin;
    cnfg_update        = 1'b1;
    #1;
    check("rdy_masked_by_update", 32'(query_rdy), 32'd0);
    tick();
    cnfg_update = 1'b0;
    model_build(int'(mx), lin);
  endtask

  task automatic wait_built(input string tag);
    int n = 0;
    while (!thresh_vld && n < 40) begin
      check({tag, "_rdy_low"}, 32'(query_rdy), 32'd0);
      tick();
      n++;
    end
    check({tag, "_build_cycles"}, 32'(n), 32'd8);
    check({tag, "_rdy_high"}, 32'(query_rdy), 32'd1);
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 8; i++) check(tag, 32'(thresh_ary[i]), 32'(m_tbl[i]));
  endtask

  task automatic send_q(input logic [15:0] s);
    exp_t e;
    query_vld   = 1'b1;
    query_score = s;
    check("query_rdy", 32'(query_rdy), 32'd1);
    e.cut = model_cut(s);
    e.cyc = cyc + 1;
    sb.push_back(e);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    query_vld = 1'b0;
    while (sb.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_thresh_vld"}, 32'(thresh_vld), 32'd0);
    check({tag, "_query_rdy"}, 32'(query_rdy), 32'd0);
    check({tag, "_resp_vld"}, 32'(resp_vld), 32'd0);
    check({tag, "_resp_cut"}, 32'(resp_cut), 32'd0);
    check({tag, "_state"}, 32'(dut.state_q), 32'(ga_pkg::IDLE));
    for (int i = 0; i < 8; i++) check({tag, "_tbl"}, 32'(thresh_ary[i]), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] s;
    rst                = 1'b1;
    cnfg_update        = 1'b0;
    cnfg_max_fit_score = '0;
    cnfg_lin_mode      = 1'b0;
    query_vld          = 1'b0;
    query_score        = '0;
    repeat (2) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) tick();
    check("idle_stays_invalid", 32'(thresh_vld), 32'd0);

    // Exponential build and directed queries.
    do_update(16'h4000, 1'b0);
    wait_built("exp");
    check_table("exp_tbl");
    send_q(16'h0180);
    send_q(16'hFFFF);
    send_q(16'h0000);
    drain();

    // Linear request (falls back to exponential when linear mode is compiled out).
    do_update(16'h4000, 1'b1);
    wait_built("lin");
    check_table("lin_tbl");
    send_q(16'h1000);
    send_q(16'hFFFF);
    send_q(16'h0000);
    drain();

    // Four back-to-back queries, then an update: old-table responses must come out.
    do_update(16'h0300, 1'b0);
    wait_built("small");
    check_table("small_tbl");
    send_q(16'h0002);
    send_q(16'h0001);
    send_q(16'h0180);
    send_q(16'h0060);
    do_update(16'hF000, 1'b1);
    wait_built("b2b");
    check_table("b2b_tbl");
    drain();

    // Restart while building at idx 4.
    do_update(16'h1234, 1'b0);
    repeat (4) tick();
    check("restart_mid_calc_vld", 32'(thresh_vld), 32'd0);
    do_update(16'h8000, 1'b1);
    wait_built("restart");
    check_table("restart_tbl");

    // Randomized configurations with mixed random and boundary scores.
    for (int r = 0; r < 6; r++) begin
      do_update(16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 1)));
      wait_built("rand");
      check_table("rand_tbl");
      for (int k = 0; k < 24; k++) begin
        if ($urandom_range(0, 3) != 0) begin
          case ($urandom_range(0, 2))
            0:       s = 16'($urandom_range(0, 16'hFFFF));
            1:       s = m_tbl[$urandom_range(0, 7)];
            default: s = m_tbl[$urandom_range(0, 7)] - 16'd1;
          endcase
          send_q(s);
        end else begin
          query_vld = 1'b0;
          tick();
        end
      end
      drain();
    end

    // Reset with a query in flight: no response may appear.
    send_q(16'hFFFF);
    query_vld = 1'b0;
    rst       = 1'b1;
    sb.delete();
    #1;
    check_reset_outputs("rst_pipe");
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("rst_pipe_no_resp", 32'(resp_vld), 32'd0);

    // Reset in the middle of a build.
    do_update(16'h4000, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_calc");
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("rst_calc_stays_idle", 32'(thresh_vld), 32'd0);

    // Recover with a fresh build after reset.
    do_update(16'h4000, 1'b0);
    wait_built("recover");
    check_table("recover_tbl");
    send_q(16'h0180);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
